div_arbiter: RTL and testbench

DIV_ARBITER -- requirements
Module: div_arbiter

---
 rtl/div_pkg.sv | 27 ++
 rtl/rr_arbiter.sv | 39 +++
 rtl/div_arbiter.sv | 200 ++++++++++++++++++++
 tb/tb_div_arbiter.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared definitions for the divider arbiter.
// - state_t: FSM state encoding used by div_arbiter.
// - default_timeout(): default WAIT-cycle budget for a given operand width.
// - idx_width(): width of a requester index (never below 1 bit).
package div_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_WAIT  = 3'd2,
        ST_RESP  = 3'd3,
        ST_DRAIN = 3'd4
    } state_t;

    // An SRT radix-4 divider retires 2 quotient bits per cycle, so 4*WID
    // leaves a generous margin before declaring the divider hung.
    localparam int TIMEOUT_PER_BIT = 4;

    function automatic int default_timeout(input int wid);
        return TIMEOUT_PER_BIT * wid;
    endfunction

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin one-hot grant.
// Ports:
//   req   - request vector, one bit per requester
//   ptr   - index with highest priority this round
//   grant - one-hot grant (all zero when no request)
// Requesters at or above ptr are searched first (lowest index wins), then
// the search wraps to the requesters below ptr.
module rr_arbiter
    import div_pkg::*;
#(
    parameter int NREQ = 2,
    localparam int PW = idx_width(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   ptr,
    output logic [NREQ-1:0] grant
);

    logic [NREQ-1:0] hi_mask;
    logic [NREQ-1:0] masked;

    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_mask
            assign hi_mask[gi] = (PW'(gi) >= ptr);
        end
    endgenerate

    assign masked = req & hi_mask;

    // x & (~x + 1) isolates the lowest set bit.
    always_comb begin
        if (|masked) begin
            grant = masked & (~masked + NREQ'(1));
        end else begin
            grant = req & (~req + NREQ'(1));
        end
    end

endmodule

// File: rtl/div_arbiter.sv
// Shares one SRT radix-4 divider among NREQ requesters.
// Ports:
//   clk, rst                      - clock, synchronous active-high reset
//   req_valid/req_ready           - per-requester operation handshake
//   req_dividend/req_divisor      - packed operands, requester i at [i*WID +: WID]
//   req_sign                      - per-requester signed-division flag
//   rsp_valid/rsp_ready           - one-hot result pending / per-requester consume
//   rsp_quotient/remainder/error  - shared result bus, valid with rsp_valid
//   div_valid, div_dividend/divisor/sign - start pulse and operands to divider
//   div_ready, div_error, div_quotient/remainder - divider completion
// A timed-out operation is answered with an error and the block then waits
// in DRAIN for the stale completion, so a busy divider is never restarted.
module div_arbiter
    import div_pkg::*;
#(
    parameter int WID     = 8,
    parameter int NREQ    = 2,
    parameter int TIMEOUT = default_timeout(WID)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NREQ-1:0]     req_valid,
    output logic [NREQ-1:0]     req_ready,
    input  logic [NREQ*WID-1:0] req_dividend,
    input  logic [NREQ*WID-1:0] req_divisor,
    input  logic [NREQ-1:0]     req_sign,
    output logic [NREQ-1:0]     rsp_valid,
    input  logic [NREQ-1:0]     rsp_ready,
    output logic [WID-1:0]      rsp_quotient,
    output logic [WID-1:0]      rsp_remainder,
    output logic                rsp_error,
    output logic                div_valid,
    output logic [WID-1:0]      div_dividend,
    output logic [WID-1:0]      div_divisor,
    output logic                div_sign,
    input  logic                div_ready,
    input  logic                div_error,
    input  logic [WID-1:0]      div_quotient,
    input  logic [WID-1:0]      div_remainder
);

    localparam int PW = idx_width(NREQ);
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    state_t         state_reg, state_next;
    logic [PW-1:0]  ptr_reg, ptr_next;
    logic [PW-1:0]  idx_reg, idx_next;
    logic           drain_reg, drain_next;
    logic [CW-1:0]  cnt_reg, cnt_next;
    logic [WID-1:0] dividend_reg, dividend_next;
    logic [WID-1:0] divisor_reg, divisor_next;
    logic           sign_reg, sign_next;
    logic [WID-1:0] quot_reg, quot_next;
    logic [WID-1:0] rem_reg, rem_next;
    logic           err_reg, err_next;

    logic [NREQ-1:0] grant;
    logic [PW-1:0]   grant_idx;
    logic [WID-1:0]  dividend_arr [NREQ];
    logic [WID-1:0]  divisor_arr [NREQ];
    logic            div_done;
    logic            div_start;
    logic            rsp_fire;
    logic            drain_live;

    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .req   (req_valid),
        .ptr   (ptr_reg),
        .grant (grant)
    );

    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_req
            assign dividend_arr[gi] = req_dividend[gi*WID +: WID];
            assign divisor_arr[gi]  = req_divisor[gi*WID +: WID];
            assign rsp_valid[gi]    = !rst && (state_reg == ST_RESP) && (idx_reg == PW'(gi));
        end
    endgenerate

    always_comb begin
        grant_idx = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                grant_idx = PW'(i);
            end
        end
    end

    assign div_done = div_ready | div_error;
    assign rsp_fire = |(rsp_valid & rsp_ready);
    // A completion arriving while the timeout response is still pending
    // means the divider is already idle, so there is nothing left to drain.
    assign drain_live = drain_reg && !div_done;

    always_comb begin
        state_next    = state_reg;
        ptr_next      = ptr_reg;
        idx_next      = idx_reg;
        drain_next    = drain_reg;
        cnt_next      = cnt_reg;
        dividend_next = dividend_reg;
        divisor_next  = divisor_reg;
        sign_next     = sign_reg;
        quot_next     = quot_reg;
        rem_next      = rem_reg;
        err_next      = err_reg;
        div_start     = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                // grant is already qualified by req_valid
                if (|grant) begin
                    dividend_next = dividend_arr[grant_idx];
                    divisor_next  = divisor_arr[grant_idx];
                    sign_next     = req_sign[grant_idx];
                    idx_next      = grant_idx;
                    ptr_next      = (grant_idx == PW'(NREQ - 1)) ? '0 : grant_idx + 1'b1;
                    state_next    = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                div_start  = 1'b1;
                cnt_next   = '0;
                state_next = ST_WAIT;
            end
            ST_WAIT: begin
                if (div_done) begin
                    quot_next  = div_quotient;
                    rem_next   = div_remainder;
                    err_next   = div_error;
                    state_next = ST_RESP;
                end else if (cnt_reg == CNT_LAST) begin
                    quot_next  = '0;
                    rem_next   = '0;
                    err_next   = 1'b1;
                    drain_next = 1'b1;
                    state_next = ST_RESP;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            ST_RESP: begin
                drain_next = drain_live;
                if (rsp_fire) begin
                    drain_next = 1'b0;
                    state_next = drain_live ? ST_DRAIN : ST_IDLE;
                end
            end
            ST_DRAIN: begin
                if (div_done) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= ST_IDLE;
            ptr_reg      <= '0;
            idx_reg      <= '0;
            drain_reg    <= 1'b0;
            cnt_reg      <= '0;
            dividend_reg <= '0;
            divisor_reg  <= '0;
            sign_reg     <= 1'b0;
            quot_reg     <= '0;
            rem_reg      <= '0;
            err_reg      <= 1'b0;
        end else begin
            state_reg    <= state_next;
            ptr_reg      <= ptr_next;
            idx_reg      <= idx_next;
            drain_reg    <= drain_next;
            cnt_reg      <= cnt_next;
            dividend_reg <= dividend_next;
            divisor_reg  <= divisor_next;
            sign_reg     <= sign_next;
            quot_reg     <= quot_next;
            rem_reg      <= rem_next;
            err_reg      <= err_next;
        end
    end

    // Outputs are forced low combinationally so they read 0 from the first
    // cycle rst is high, before the registers have been cleared.
    assign req_ready     = (!rst && state_reg == ST_IDLE) ? grant : '0;
    assign div_valid     = !rst && div_start;
    assign div_dividend  = rst ? '0 : dividend_reg;
    assign div_divisor   = rst ? '0 : divisor_reg;
    assign div_sign      = !rst && sign_reg;
    assign rsp_quotient  = rst ? '0 : quot_reg;
    assign rsp_remainder = rst ? '0 : rem_reg;
    assign rsp_error     = !rst && (state_reg == ST_RESP) && err_reg;

endmodule

// File: tb/tb_div_arbiter.sv
// Scoreboard bench for div_arbiter with a behavioural divider model.
// Stimulus pushes hand-computed responses into a queue on acceptance; a
// negedge monitor pops and compares on every rsp handshake.
module tb_div_arbiter;

    localparam int WID     = 8;
    localparam int NREQ    = 2;
    localparam int TIMEOUT = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                rst;
    logic [NREQ-1:0]     req_valid, req_ready, req_sign;
    logic [NREQ*WID-1:0] req_dividend, req_divisor;
    logic [NREQ-1:0]     rsp_valid, rsp_ready;
    logic [WID-1:0]      rsp_quotient, rsp_remainder;
    logic                rsp_error;
    logic                div_valid, div_sign, div_ready, div_error;
    logic [WID-1:0]      div_dividend, div_divisor, div_quotient, div_remainder;

    logic           rv [NREQ];
    logic           rs [NREQ];
    logic [WID-1:0] ra [NREQ];
    logic [WID-1:0] rb [NREQ];

    assign req_valid    = {rv[1], rv[0]};
    assign req_sign     = {rs[1], rs[0]};
    assign req_dividend = {ra[1], ra[0]};
    assign req_divisor  = {rb[1], rb[0]};

    div_arbiter #(.WID(WID), .NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_dividend  (req_dividend),
        .req_divisor   (req_divisor),
        .req_sign      (req_sign),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_quotient  (rsp_quotient),
        .rsp_remainder (rsp_remainder),
        .rsp_error     (rsp_error),
        .div_valid     (div_valid),
        .div_dividend  (div_dividend),
        .div_divisor   (div_divisor),
        .div_sign      (div_sign),
        .div_ready     (div_ready),
        .div_error     (div_error),
        .div_quotient  (div_quotient),
        .div_remainder (div_remainder)
    );

    // ---------------- divider model ----------------
    logic           silent, kick;
    logic           busy;
    int             lat_cnt;
    logic [WID-1:0] mq, mr;

    function automatic logic [WID-1:0] mdl_q(input logic [WID-1:0] a, b, input logic s);
        if (s) return WID'($signed(a) / $signed(b));
        return a / b;
    endfunction

    function automatic logic [WID-1:0] mdl_r(input logic [WID-1:0] a, b, input logic s);
        if (s) return WID'($signed(a) % $signed(b));
        return a % b;
    endfunction

    always @(posedge clk) begin
        div_ready <= 1'b0;
        div_error <= 1'b0;
        if (rst) begin
            busy          <= 1'b0;
            lat_cnt       <= 0;
            mq            <= '0;
            mr            <= '0;
            div_quotient  <= '0;
            div_remainder <= '0;
        end else if (kick) begin
            div_ready <= 1'b1;
        end else if (div_valid && !silent) begin
            if (div_divisor == '0) begin
                div_error     <= 1'b1;
                div_quotient  <= '1;
                div_remainder <= div_dividend;
            end else if (div_divisor == WID'(1)) begin
                div_ready     <= 1'b1;
                div_quotient  <= div_dividend;
                div_remainder <= '0;
            end else begin
                busy    <= 1'b1;
                lat_cnt <= 4;
                mq      <= mdl_q(div_dividend, div_divisor, div_sign);
                mr      <= mdl_r(div_dividend, div_divisor, div_sign);
            end
        end else if (busy) begin
            if (lat_cnt == 0) begin
                busy          <= 1'b0;
                div_ready     <= 1'b1;
                div_quotient  <= mq;
                div_remainder <= mr;
            end else begin
                lat_cnt <= lat_cnt - 1;
            end
        end
    end

    // ---------------- scoreboard ----------------
    typedef struct {
        logic           idx;
        logic [WID-1:0] q;
        logic [WID-1:0] r;
        logic           e;
    } exp_t;

    exp_t sb [$];
    logic acc_log [$];
    exp_t mon_e;
    int   checks   = 0;
    int   failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && ((rsp_valid & rsp_ready) != '0)) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_rsp: rsp_valid=%b with no response expected", rsp_valid);
            end else begin
                mon_e = sb.pop_front();
                $display("rsp req%0d q=%02h r=%02h err=%0b", mon_e.idx, rsp_quotient, rsp_remainder, rsp_error);
                chk("rsp_onehot", 32'(rsp_valid), mon_e.idx ? 32'h2 : 32'h1);
                chk("rsp_quotient", 32'(rsp_quotient), 32'(mon_e.q));
                chk("rsp_remainder", 32'(rsp_remainder), 32'(mon_e.r));
                chk("rsp_error", 32'(rsp_error), 32'(mon_e.e));
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic drive(input logic i, input logic [WID-1:0] a, b, input logic s,
                         input bit exp_rsp, input logic [WID-1:0] qe, re, input logic ee);
        bit ok;
        ok    = 1'b0;
        rv[i] = 1'b1;
        ra[i] = a;
        rb[i] = b;
        rs[i] = s;
        for (int n = 0; n < 200 && !ok; n++) begin
            @(negedge clk);
            if (req_ready[i]) begin
                ok = 1'b1;
                if (exp_rsp) sb.push_back(exp_t'{idx: i, q: qe, r: re, e: ee});
                acc_log.push_back(i);
                $display("req%0d accepted a=%02h b=%02h sign=%0b", i, a, b, s);
            end
        end
        if (!ok) begin
            checks++;
            failures++;
            $display("FAIL accept_timeout: req%0d got no grant, required a grant", i);
        end else begin
            @(posedge clk);
        end
        #1;
        rv[i] = 1'b0;
    endtask

    task automatic wait_rsp(output int k);
        k = 0;
        for (int n = 1; n <= 100 && k == 0; n++) begin
            @(negedge clk);
            if (rsp_valid != '0) k = n;
        end
        if (k == 0) begin
            checks++;
            failures++;
            $display("FAIL rsp_timeout: rsp_valid stayed 0, required a response");
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_empty();
        for (int n = 0; n < 500 && sb.size() != 0; n++) @(negedge clk);
        idle(1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // ---------------- directed sequence ----------------
    initial begin
        int k;
        rst       = 1'b1;
        rsp_ready = '1;
        silent    = 1'b0;
        kick      = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            rv[i] = 1'b0; rs[i] = 1'b0; ra[i] = '0; rb[i] = '0;
        end
        // A request raised during reset must not be granted.
        rv[0] = 1'b1; ra[0] = 8'h55; rb[0] = 8'h03;
        repeat (2) @(negedge clk);
        chk("rst_req_ready", 32'(req_ready), 32'h0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("rst_div_valid", 32'(div_valid), 32'h0);
        chk("rst_rsp_error", 32'(rsp_error), 32'h0);
        chk("rst_quotient", 32'(rsp_quotient), 32'h0);
        chk("rst_div_dividend", 32'(div_dividend), 32'h0);
        rv[0] = 1'b0;
        rst = 1'b0;
        idle(2);

        // Unsigned 100/7 from req0
        drive(1'b0, 8'd100, 8'd7, 1'b0, 1'b1, 8'd14, 8'd2, 1'b0);
        wait_empty();

        // Signed -7/2 from req1, response held while its rsp_ready is low
        // (req0's rsp_ready bit is high and must be ignored).
        rsp_ready = 2'b01;
        drive(1'b1, 8'hF9, 8'h02, 1'b1, 1'b1, 8'hFD, 8'hFF, 1'b0);
        wait_rsp(k);
        chk("hold_valid_first", 32'(rsp_valid), 32'h2);
        repeat (3) @(negedge clk);
        chk("hold_valid_later", 32'(rsp_valid), 32'h2);
        chk("hold_quotient", 32'(rsp_quotient), 32'hFD);
        chk("hold_remainder", 32'(rsp_remainder), 32'hFF);
        @(posedge clk); #1;
        rsp_ready = 2'b11;
        wait_empty();

        // Divide by zero from req0
        drive(1'b0, 8'd50, 8'd0, 1'b0, 1'b1, 8'hFF, 8'd50, 1'b1);
        wait_empty();

        // Divisor 1: minimum latency accept -> rsp_valid
        drive(1'b0, 8'd9, 8'd1, 1'b0, 1'b1, 8'd9, 8'd0, 1'b0);
        wait_rsp(k);
        chk("latency_div1", 32'(k), 32'd3);
        wait_empty();

        // req1 op leaves ptr at 0
        drive(1'b1, 8'd200, 8'd13, 1'b0, 1'b1, 8'd15, 8'd5, 1'b0);
        wait_empty();

        // Simultaneous requests, ptr=0, then an immediate repeat from req0
        acc_log.delete();
        fork
            begin
                drive(1'b0, 8'd60, 8'd5, 1'b0, 1'b1, 8'd12, 8'd0, 1'b0);
                drive(1'b0, 8'd255, 8'd16, 1'b0, 1'b1, 8'd15, 8'd15, 1'b0);
            end
            drive(1'b1, 8'h0E, 8'hFC, 1'b1, 1'b1, 8'hFD, 8'h02, 1'b0);
        join
        wait_empty();
        chk("rr_count", 32'(acc_log.size()), 32'd3);
        if (acc_log.size() == 3) begin
            chk("rr_first", 32'(acc_log[0]), 32'd0);
            chk("rr_second", 32'(acc_log[1]), 32'd1);
            chk("rr_third", 32'(acc_log[2]), 32'd0);
        end

        // Timeout: divider silent, error response, then DRAIN
        silent = 1'b1;
        drive(1'b1, 8'd77, 8'd3, 1'b0, 1'b1, 8'd0, 8'd0, 1'b1);
        wait_rsp(k);
        chk("latency_timeout", 32'(k), 32'(TIMEOUT + 2));
        rv[0] = 1'b1; ra[0] = 8'd21; rb[0] = 8'd4; rs[0] = 1'b0;
        for (int n = 0; n < 3; n++) begin
            @(negedge clk);
            chk("drain_no_grant", 32'(req_ready), 32'h0);
            chk("drain_no_start", 32'(div_valid), 32'h0);
        end
        kick = 1'b1;
        @(negedge clk);
        kick   = 1'b0;
        silent = 1'b0;
        drive(1'b0, 8'd21, 8'd4, 1'b0, 1'b1, 8'd5, 8'd1, 1'b0);
        wait_empty();

        // Reset in the middle of WAIT abandons the operation
        silent = 1'b1;
        drive(1'b1, 8'd40, 8'd6, 1'b0, 1'b0, 8'd0, 8'd0, 1'b0);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("midrst_div_valid", 32'(div_valid), 32'h0);
        chk("midrst_div_dividend", 32'(div_dividend), 32'h0);
        chk("midrst_div_divisor", 32'(div_divisor), 32'h0);
        chk("midrst_rsp_error", 32'(rsp_error), 32'h0);
        @(negedge clk);
        rst    = 1'b0;
        silent = 1'b0;
        for (int n = 0; n < 5; n++) begin
            @(negedge clk);
            chk("post_rst_no_rsp", 32'(rsp_valid), 32'h0);
        end
        idle(1);
        drive(1'b1, 8'd40, 8'd6, 1'b0, 1'b1, 8'd6, 8'd4, 1'b0);
        wait_empty();

        chk("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
